// File: rtl/bb_ext_arbiter.sv
// Shares one fixed-latency external Blackbone memory port between NUM_REQ requesters:
// round-robin arbitration with bounded bursts, read data routed back by requester id.
module bb_ext_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*AW-1:0]  req_addr_i,
    input  logic [NUM_REQ*DW-1:0]  req_din_i,
    input  logic [NUM_REQ-1:0]     req_en_i,
    input  logic [NUM_REQ-1:0]     req_we_i,
    output logic [NUM_REQ-1:0]     req_gnt_o,
    output logic [DW-1:0]          req_dout_o,
    output logic [NUM_REQ-1:0]     req_rvalid_o,
    output logic [AW-1:0]          bb_ext_addr_o,
    output logic [DW-1:0]          bb_ext_din_o,
    output logic                   bb_ext_en_o,
    output logic                   bb_ext_we_o,
    input  logic [DW-1:0]          bb_ext_dout_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d;
    logic          owner_valid_q, owner_valid_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic          gnt_any;
    logic [IW-1:0] gnt_id, gnt_nxt;

    logic [READ_LATENCY-1:0]         rd_vld_pipe_q;
    logic [READ_LATENCY-1:0][IW-1:0] rd_id_pipe_q;

    // Owner keeps the port while it still requests and has burst budget left.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (owner_valid_q && req_en_i[owner_q] && (burst_cnt_q < CW'(MAX_BURST))) begin
            gnt_any = 1'b1;
            gnt_id  = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_any && req_en_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = IW'(idx);
                end
            end
        end
    end

    assign gnt_nxt       = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    assign req_gnt_o     = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign bb_ext_en_o   = gnt_any;
    assign bb_ext_addr_o = gnt_any ? req_addr_i[int'(gnt_id)*AW +: AW] : '0;
    assign bb_ext_din_o  = gnt_any ? req_din_i[int'(gnt_id)*DW +: DW] : '0;
    assign bb_ext_we_o   = gnt_any ? req_we_i[gnt_id] : 1'b0;

    always_comb begin
        logic [CW-1:0] cnt_new;
        cnt_new       = '0;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        burst_cnt_d   = burst_cnt_q;
        if (owner_valid_q && !req_en_i[owner_q]) begin
            owner_valid_d = 1'b0;
            burst_cnt_d   = '0;
        end
        if (gnt_any) begin
            if (owner_valid_q && gnt_id == owner_q) begin
                cnt_new = burst_cnt_q + 1'b1;
            end else begin
                owner_d       = gnt_id;
                owner_valid_d = 1'b1;
                cnt_new       = CW'(1);
                ptr_d         = gnt_nxt;
            end
            burst_cnt_d = cnt_new;
            // Budget exhausted: release ownership; a lone requester simply wins the search again.
            if (cnt_new == CW'(MAX_BURST)) begin
                ptr_d         = gnt_nxt;
                owner_valid_d = 1'b0;
                burst_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            burst_cnt_q   <= '0;
            rd_vld_pipe_q <= '0;
            rd_id_pipe_q  <= '0;
        end else begin
            ptr_q            <= ptr_d;
            owner_q          <= owner_d;
            owner_valid_q    <= owner_valid_d;
            burst_cnt_q      <= burst_cnt_d;
            rd_vld_pipe_q[0] <= gnt_any & ~req_we_i[gnt_id];
            rd_id_pipe_q[0]  <= gnt_id;
            for (int s = 1; s < READ_LATENCY; s++) begin
                rd_vld_pipe_q[s] <= rd_vld_pipe_q[s-1];
                rd_id_pipe_q[s]  <= rd_id_pipe_q[s-1];
            end
        end
    end

    assign req_rvalid_o = rd_vld_pipe_q[READ_LATENCY-1] ?
                          (NUM_REQ'(1) << rd_id_pipe_q[READ_LATENCY-1]) : '0;
    assign req_dout_o   = bb_ext_dout_i;
endmodule

// File: tb/tb_bb_ext_arbiter.sv
// Directed bench: three arbiter instances with different latency/burst settings,
// each exercised in turn with hand-computed expectations.
module tb_bb_ext_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ND-1:0][NR*AW-1:0] addr;
    logic [ND-1:0][NR*DW-1:0] din;
    logic [ND-1:0][NR-1:0]    en, we;
    logic [ND-1:0][DW-1:0]    mdout;
    wire  [ND-1:0][NR-1:0]    gnt, rvalid;
    wire  [ND-1:0][DW-1:0]    rdout, xdin;
    wire  [ND-1:0][AW-1:0]    xaddr;
    wire  [ND-1:0]            xen, xwe;

    // Instance 0: latency 2, burst 4; instance 1: latency 1, burst 1; instance 2: latency 3, burst 4.
    for (genvar i = 0; i < ND; i++) begin : g_dut
        bb_ext_arbiter #(
            .NUM_REQ(NR), .AW(AW), .DW(DW),
            .READ_LATENCY(i == 0 ? 2 : (i == 1 ? 1 : 3)),
            .MAX_BURST(i == 1 ? 1 : 4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_addr_i(addr[i]), .req_din_i(din[i]), .req_en_i(en[i]), .req_we_i(we[i]),
            .req_gnt_o(gnt[i]), .req_dout_o(rdout[i]), .req_rvalid_o(rvalid[i]),
            .bb_ext_addr_o(xaddr[i]), .bb_ext_din_o(xdin[i]), .bb_ext_en_o(xen[i]),
            .bb_ext_we_o(xwe[i]), .bb_ext_dout_i(mdout[i])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setr(input int d, input int r, input bit e, input bit w,
                        input logic [31:0] a, input logic [31:0] dd);
        en[d][r] = e;
        we[d][r] = w;
        addr[d][r*AW +: AW] = a;
        din[d][r*DW +: DW]  = dd;
    endtask

    task automatic do_reset();
        en = '0; we = '0; addr = '0; din = '0; mdout = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_bus(input int d, input string tag, input logic [3:0] g, input bit w,
                             input logic [31:0] a, input logic [31:0] dd);
        check({tag, " gnt"},  64'(gnt[d]),  64'(g));
        check({tag, " en"},   64'(xen[d]),  64'(g != 0));
        check({tag, " we"},   64'(xwe[d]),  64'(w));
        check({tag, " addr"}, 64'(xaddr[d]), 64'(a));
        check({tag, " din"},  64'(xdin[d]),  64'(dd));
    endtask

    initial begin
        logic [3:0] bg [6];
        bg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};

        do_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst%0d", d), 64'(gnt[d]), 64'd0);
            check($sformatf("rst%0d rvalid", d), 64'(rvalid[d]), 64'd0);
            check($sformatf("rst%0d en", d), 64'(xen[d]), 64'd0);
            check($sformatf("rst%0d addr", d), 64'(xaddr[d]), 64'd0);
        end

        // Single read, latency 2
        setr(0, 0, 1, 0, 32'h100, 32'h0);
        #1 check_bus(0, "rd1 c0", 4'b0001, 0, 32'h100, 32'h0);
        step();
        setr(0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("rd1 c1 rvalid", 64'(rvalid[0]), 64'd0);
        step();
        mdout[0] = 32'hCAFE0001;
        #1 check("rd1 c2 rvalid", 64'(rvalid[0]), 64'b0001);
        check("rd1 c2 dout", 64'(rdout[0]), 64'hCAFE0001);
        step();
        #1 check("rd1 c3 rvalid", 64'(rvalid[0]), 64'd0);

        // Round robin with burst 1, latency 1
        for (int r = 0; r < NR; r++) setr(1, r, 1, 0, 32'(r * 16), 32'h0);
        for (int k = 0; k <= NR; k++) begin
            if (k > 0) mdout[1] = 32'hD0000000 + 32'(k - 1);
            #1;
            if (k < NR) check_bus(1, $sformatf("rr c%0d", k), 4'(1 << k), 0, 32'(k * 16), 32'h0);
            else        check_bus(1, "rr idle", 4'b0000, 0, 32'h0, 32'h0);
            check($sformatf("rr c%0d rvalid", k), 64'(rvalid[1]), (k == 0) ? 64'd0 : 64'(1 << (k - 1)));
            if (k > 0) check($sformatf("rr c%0d dout", k), 64'(rdout[1]), 64'hD0000000 + 64'(k - 1));
            step();
            if (k < NR) setr(1, k, 0, 0, 32'h0, 32'h0);
        end

        // Burst limit: req0 continuous, req1 waits for four grants
        do_reset();
        setr(0, 0, 1, 1, 32'h40, 32'h1111);
        setr(0, 1, 1, 1, 32'h44, 32'h2222);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) setr(0, 1, 0, 0, 32'h0, 32'h0);
            #1;
            check_bus(0, $sformatf("bur c%0d", c), bg[c], 1,
                      (bg[c] == 4'b0001) ? 32'h40 : 32'h44,
                      (bg[c] == 4'b0001) ? 32'h1111 : 32'h2222);
            check($sformatf("bur c%0d rvalid", c), 64'(rvalid[0]), 64'd0);
            if (c == 4) check("bur cnt", 64'(g_dut[0].u_dut.burst_cnt_q), 64'd0);
            step();
        end
        setr(0, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Write from req2, then read from req3
        setr(0, 2, 1, 1, 32'h20, 32'h55AA);
        #1 check_bus(0, "wr c0", 4'b0100, 1, 32'h20, 32'h55AA);
        step();
        setr(0, 2, 0, 0, 32'h0, 32'h0);
        setr(0, 3, 1, 0, 32'h20, 32'h0);
        #1 check_bus(0, "wr c1", 4'b1000, 0, 32'h20, 32'h0);
        check("wr c1 rvalid", 64'(rvalid[0]), 64'd0);
        step();
        setr(0, 3, 0, 0, 32'h0, 32'h0);
        #1 check("wr c2 rvalid", 64'(rvalid[0]), 64'd0);
        step();
        mdout[0] = 32'h55AA;
        #1 check("wr c3 rvalid", 64'(rvalid[0]), 64'b1000);
        check("wr c3 dout", 64'(rdout[0]), 64'h55AA);
        step();
        #1 check("wr c4 rvalid", 64'(rvalid[0]), 64'd0);

        // Reset one cycle after a granted read, latency 3
        do_reset();
        setr(2, 0, 1, 0, 32'h300, 32'h0);
        #1 check_bus(2, "mrst c0", 4'b0001, 0, 32'h300, 32'h0);
        step();
        setr(2, 0, 0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        #1 check("mrst c1 rvalid", 64'(rvalid[2]), 64'd0);
        step();
        rst = 1'b0;
        setr(2, 0, 1, 0, 32'h320, 32'h0);
        setr(2, 1, 1, 0, 32'h310, 32'h0);
        #1 check_bus(2, "mrst c2", 4'b0001, 0, 32'h320, 32'h0);
        check("mrst c2 rvalid", 64'(rvalid[2]), 64'd0);
        step();
        setr(2, 0, 0, 0, 32'h0, 32'h0);
        #1 check_bus(2, "mrst c3", 4'b0010, 0, 32'h310, 32'h0);
        check("mrst c3 rvalid", 64'(rvalid[2]), 64'd0);
        step();
        setr(2, 1, 0, 0, 32'h0, 32'h0);
        #1 check("mrst c4 rvalid", 64'(rvalid[2]), 64'd0);
        step();
        #1 check("mrst c5 rvalid", 64'(rvalid[2]), 64'b0001);
        step();
        #1 check("mrst c6 rvalid", 64'(rvalid[2]), 64'b0010);

        // Idle: fields present but no enables
        for (int r = 0; r < NR; r++) setr(0, r, 0, 1, 32'hA000 + 32'(r), 32'hB000 + 32'(r));
        for (int c = 0; c < 10; c++) begin
            step();
            #1 check_bus(0, $sformatf("idle c%0d", c), 4'b0000, 0, 32'h0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
